// File: rtl/alu_cmd_driver.sv
// Command-side driver for the 8-bit accumulator ALU.
// Host commands are queued in a small FIFO. Each one is issued to the ALU as
// registered mux/operand/select drives. After the ALU latency the result is
// captured and handed back over a valid/ready response channel. An errored
// response (overflow or illegal op) is followed by a one-cycle accumulator reset.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | nothing in flight; leaves as soon as the FIFO has an entry
//   ISSUE   | pop head, drive ALU (legal op) or build error response (op 7)
//   WAIT    | count down the ALU latency, capture result/overflow at zero
//   RESP    | hold rsp_valid/rsp_data/rsp_err until the host takes them
//   ERROR   | one cycle of in_selector=reset with zeroed operands
module alu_cmd_driver #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic             cmd_chain,
    output logic [2:0]       in_selector,
    output logic [WIDTH-1:0] num1,
    output logic [WIDTH-1:0] num2,
    output logic [6:0]       out_selector,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_overflow,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,
    output logic             busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;
    localparam int EW = 3 + 2 * WIDTH + 1;

    localparam logic [2:0] SEL_PERSIST = 3'b100;
    localparam logic [2:0] SEL_LOAD    = 3'b010;
    localparam logic [2:0] SEL_RESET   = 3'b001;
    localparam logic [2:0] OP_ILLEGAL  = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP,
        S_ERROR
    } state_t;

    state_t state, state_nxt;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    logic [EW-1:0]    fifo_mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             full, empty, push, pop;
    logic [2:0]       head_op;
    logic [WIDTH-1:0] head_a, head_b;
    logic             head_chain;

    assign full      = (count == (AW + 1)'(DEPTH));
    assign empty     = (count == '0);
    // cmd_ready depends only on the stored count, never on this cycle's pop.
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    // ISSUE is only entered with a non-empty FIFO, so a pop is always legal.
    assign pop       = (state == S_ISSUE);

    assign {head_op, head_a, head_b, head_chain} = fifo_mem[rd_ptr];

    // FIFO storage write; data needs no reset since count gates its use.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {cmd_op, cmd_a, cmd_b, cmd_chain};
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    logic [CW-1:0]    lat_cnt, lat_cnt_nxt;
    logic [2:0]       in_sel_nxt;
    logic [WIDTH-1:0] num1_nxt, num2_nxt;
    logic [6:0]       out_sel_nxt;
    logic             rsp_valid_nxt;
    logic [WIDTH-1:0] rsp_data_nxt;
    logic             rsp_err_nxt;

    // State register and all registered ALU/host-side outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            lat_cnt      <= '0;
            in_selector  <= SEL_RESET;
            num1         <= '0;
            num2         <= '0;
            out_selector <= '0;
            rsp_valid    <= 1'b0;
            rsp_data     <= '0;
            rsp_err      <= 1'b0;
        end else begin
            state        <= state_nxt;
            lat_cnt      <= lat_cnt_nxt;
            in_selector  <= in_sel_nxt;
            num1         <= num1_nxt;
            num2         <= num2_nxt;
            out_selector <= out_sel_nxt;
            rsp_valid    <= rsp_valid_nxt;
            rsp_data     <= rsp_data_nxt;
            rsp_err      <= rsp_err_nxt;
        end
    end

    // Next state and next register values; the ALU holds its accumulator by default.
    always_comb begin
        state_nxt     = state;
        lat_cnt_nxt   = lat_cnt;
        in_sel_nxt    = SEL_PERSIST;
        num1_nxt      = num1;
        num2_nxt      = num2;
        out_sel_nxt   = out_selector;
        rsp_valid_nxt = rsp_valid;
        rsp_data_nxt  = rsp_data;
        rsp_err_nxt   = rsp_err;

        case (state)
            S_IDLE: begin
                if (!empty) begin
                    state_nxt = S_ISSUE;
                end
            end

            S_ISSUE: begin
                if (head_op == OP_ILLEGAL) begin
                    // Leave every ALU drive exactly as it was.
                    in_sel_nxt    = in_selector;
                    rsp_data_nxt  = '0;
                    rsp_err_nxt   = 1'b1;
                    rsp_valid_nxt = 1'b1;
                    state_nxt     = S_RESP;
                end else begin
                    num1_nxt    = head_a;
                    num2_nxt    = head_b;
                    out_sel_nxt = 7'b1000000 >> head_op;
                    in_sel_nxt  = head_chain ? SEL_PERSIST : SEL_LOAD;
                    lat_cnt_nxt = CW'(ALU_LAT);
                    state_nxt   = S_WAIT;
                end
            end

            S_WAIT: begin
                lat_cnt_nxt = lat_cnt - 1'b1;
                // Capture on the edge where the counter reaches zero.
                if (lat_cnt <= CW'(1)) begin
                    lat_cnt_nxt   = '0;
                    rsp_data_nxt  = alu_result;
                    rsp_err_nxt   = alu_overflow;
                    rsp_valid_nxt = 1'b1;
                    state_nxt     = S_RESP;
                end
            end

            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_nxt = 1'b0;
                    if (rsp_err) begin
                        // Reset drive is registered on entry so it is seen
                        // by the ALU for exactly the ERROR cycle.
                        in_sel_nxt = SEL_RESET;
                        num1_nxt   = '0;
                        num2_nxt   = '0;
                        state_nxt  = S_ERROR;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end

            S_ERROR: begin
                state_nxt = S_IDLE;
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign busy = (state != S_IDLE) || !empty;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed bench for alu_cmd_driver with a behavioural accumulator ALU model.
module tb_alu_cmd_driver;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_a, cmd_b;
    logic             cmd_chain;
    logic [2:0]       in_selector;
    logic [WIDTH-1:0] num1, num2;
    logic [6:0]       out_selector;
    logic [WIDTH-1:0] alu_result;
    logic             alu_overflow;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_err;
    logic             busy;

    int n_cmp = 0;
    int n_bad = 0;

    logic [2:0]       f_op  [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5};
    logic [WIDTH-1:0] f_a   [5] = '{8'hF0, 8'hF0, 8'h55, 8'hFF, 8'h0A};
    logic [WIDTH-1:0] f_b   [5] = '{8'h3C, 8'h0F, 8'h00, 8'h0F, 8'h03};
    logic [WIDTH-1:0] f_exp [5] = '{8'h30, 8'hFF, 8'hAA, 8'hF0, 8'h07};

    always #5 clk = ~clk;

    alu_cmd_driver #(.WIDTH(WIDTH), .DEPTH(4), .ALU_LAT(1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_a        (cmd_a),
        .cmd_b        (cmd_b),
        .cmd_chain    (cmd_chain),
        .in_selector  (in_selector),
        .num1         (num1),
        .num2         (num2),
        .out_selector (out_selector),
        .alu_result   (alu_result),
        .alu_overflow (alu_overflow),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_err      (rsp_err),
        .busy         (busy)
    );

    // ALU model: combinational result from the current drives, accumulator
    // updated on accepted good responses and cleared by the reset select.
    logic [WIDTH-1:0]   acc, opa;
    logic [2*WIDTH-1:0] prod;

    always_comb begin
        opa = (in_selector == 3'b100) ? acc : (in_selector == 3'b010) ? num1 : '0;
        prod = opa * num2;
        alu_result = '0;
        alu_overflow = 1'b0;
        case (out_selector)
            7'b1000000: alu_result = opa & num2;
            7'b0100000: alu_result = opa | num2;
            7'b0010000: alu_result = ~opa;
            7'b0001000: alu_result = opa ^ num2;
            7'b0000100: alu_result = opa + num2;
            7'b0000010: alu_result = opa - num2;
            7'b0000001: begin
                alu_result = prod[WIDTH-1:0];
                alu_overflow = |prod[2*WIDTH-1:WIDTH];
            end
            default: alu_result = '0;
        endcase
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc <= '0;
        else if (in_selector == 3'b001) acc <= '0;
        else if (rsp_valid && rsp_ready && !rsp_err) acc <= rsp_data;
    end

    // Present one command at a negedge and return at the negedge after it is taken.
    task automatic push_cmd(input logic [2:0] op, input logic [WIDTH-1:0] a,
                            input logic [WIDTH-1:0] b, input logic chain);
        int n = 0;
        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_chain = chain;
        while (!cmd_ready && n < 40) begin @(negedge clk); n++; end
        n_cmp++;
        if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL push_timeout: cmd_ready=%0b required 1", cmd_ready); end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag);
        int n = 0;
        while (!rsp_valid && n < 40) begin @(negedge clk); n++; end
        n_cmp++;
        if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL %s rsp_timeout: rsp_valid=%0b required 1", tag, rsp_valid); end
    endtask

    task automatic ack_rsp();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (in_selector !== 3'b001) begin n_bad++; $display("FAIL rst_in_sel: got %b want 001", in_selector); end
        n_cmp++; if (num1 !== 8'h00) begin n_bad++; $display("FAIL rst_num1: got %0h want 0", num1); end
        n_cmp++; if (num2 !== 8'h00) begin n_bad++; $display("FAIL rst_num2: got %0h want 0", num2); end
        n_cmp++; if (out_selector !== 7'b0) begin n_bad++; $display("FAIL rst_out_sel: got %b want 0", out_selector); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_rsp_valid: got %0b want 0", rsp_valid); end
        n_cmp++; if (rsp_data !== 8'h00) begin n_bad++; $display("FAIL rst_rsp_data: got %0h want 0", rsp_data); end
        n_cmp++; if (rsp_err !== 1'b0) begin n_bad++; $display("FAIL rst_rsp_err: got %0b want 0", rsp_err); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %0b want 0", busy); end
        rst_n = 1'b1;
        #1;
        n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rst_cmd_ready: got %0b want 1", cmd_ready); end
        @(negedge clk);
    endtask

    task automatic test_add();
        push_cmd(3'd4, 8'd20, 8'd22, 1'b0);
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL add_early1: rsp_valid=%0b want 0", rsp_valid); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL add_busy: got %0b want 1", busy); end
        @(negedge clk);
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL add_early2: rsp_valid=%0b want 0", rsp_valid); end
        @(negedge clk);
        n_cmp++; if (in_selector !== 3'b010) begin n_bad++; $display("FAIL add_in_sel: got %b want 010", in_selector); end
        n_cmp++; if (out_selector !== 7'b0000100) begin n_bad++; $display("FAIL add_out_sel: got %b want 0000100", out_selector); end
        n_cmp++; if (num1 !== 8'd20 || num2 !== 8'd22) begin n_bad++; $display("FAIL add_nums: got %0d,%0d want 20,22", num1, num2); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL add_early3: rsp_valid=%0b want 0", rsp_valid); end
        @(negedge clk);
        n_cmp++; if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL add_latency: rsp_valid=%0b want 1", rsp_valid); end
        n_cmp++; if (rsp_data !== 8'd42) begin n_bad++; $display("FAIL add_data: got %0d want 42", rsp_data); end
        n_cmp++; if (rsp_err !== 1'b0) begin n_bad++; $display("FAIL add_err: got %0b want 0", rsp_err); end
        ack_rsp();
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL add_ack: rsp_valid=%0b want 0", rsp_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL add_idle: busy=%0b want 0", busy); end
        n_cmp++; if (in_selector !== 3'b100) begin n_bad++; $display("FAIL add_persist: got %b want 100", in_selector); end
    endtask

    task automatic test_chain();
        push_cmd(3'd4, 8'd5, 8'd3, 1'b0);
        wait_rsp("chain_load");
        n_cmp++; if (rsp_data !== 8'd8) begin n_bad++; $display("FAIL chain_load_data: got %0d want 8", rsp_data); end
        ack_rsp();
        push_cmd(3'd6, 8'd99, 8'd4, 1'b1);
        repeat (2) @(negedge clk);
        n_cmp++; if (in_selector !== 3'b100) begin n_bad++; $display("FAIL chain_in_sel: got %b want 100", in_selector); end
        n_cmp++; if (out_selector !== 7'b0000001) begin n_bad++; $display("FAIL chain_out_sel: got %b want 0000001", out_selector); end
        wait_rsp("chain_mult");
        n_cmp++; if (rsp_data !== 8'd32) begin n_bad++; $display("FAIL chain_data: got %0d want 32", rsp_data); end
        n_cmp++; if (rsp_err !== 1'b0) begin n_bad++; $display("FAIL chain_err: got %0b want 0", rsp_err); end
        ack_rsp();
    endtask

    task automatic test_illegal();
        push_cmd(3'd7, 8'h11, 8'h22, 1'b0);
        wait_rsp("illegal");
        n_cmp++; if (rsp_data !== 8'h00) begin n_bad++; $display("FAIL ill_data: got %0h want 0", rsp_data); end
        n_cmp++; if (rsp_err !== 1'b1) begin n_bad++; $display("FAIL ill_err: got %0b want 1", rsp_err); end
        n_cmp++; if (out_selector !== 7'b0000001) begin n_bad++; $display("FAIL ill_out_sel: got %b want 0000001", out_selector); end
        n_cmp++; if (num1 !== 8'd99 || num2 !== 8'd4) begin n_bad++; $display("FAIL ill_nums: got %0d,%0d want 99,4", num1, num2); end
        ack_rsp();
        n_cmp++; if (in_selector !== 3'b001) begin n_bad++; $display("FAIL ill_reset_pulse: got %b want 001", in_selector); end
        n_cmp++; if (num1 !== 8'h00 || num2 !== 8'h00) begin n_bad++; $display("FAIL ill_reset_nums: got %0h,%0h want 0,0", num1, num2); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL ill_err_busy: got %0b want 1", busy); end
        @(negedge clk);
        n_cmp++; if (in_selector !== 3'b100) begin n_bad++; $display("FAIL ill_after: got %b want 100", in_selector); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ill_idle: busy=%0b want 0", busy); end
    endtask

    task automatic test_overflow();
        push_cmd(3'd6, 8'd32, 8'd16, 1'b0);
        wait_rsp("ovf");
        n_cmp++; if (rsp_data !== 8'h00) begin n_bad++; $display("FAIL ovf_data: got %0h want 0", rsp_data); end
        n_cmp++; if (rsp_err !== 1'b1) begin n_bad++; $display("FAIL ovf_err: got %0b want 1", rsp_err); end
        ack_rsp();
        n_cmp++; if (in_selector !== 3'b001) begin n_bad++; $display("FAIL ovf_reset_pulse: got %b want 001", in_selector); end
        @(negedge clk);
        n_cmp++; if (in_selector !== 3'b100) begin n_bad++; $display("FAIL ovf_after: got %b want 100", in_selector); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ovf_idle: busy=%0b want 0", busy); end
    endtask

    task automatic test_fifo_full();
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_cmd(f_op[i], f_a[i], f_b[i], 1'b0);
        n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready: got %0b want 0", cmd_ready); end
        cmd_valid = 1'b1; cmd_op = 3'd0; cmd_a = 8'h01; cmd_b = 8'h01; cmd_chain = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL full_hold%0d: cmd_ready=%0b want 0", i, cmd_ready); end
        end
        cmd_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wait_rsp("full");
            n_cmp++; if (rsp_data !== f_exp[i]) begin n_bad++; $display("FAIL full_data%0d: got %0h want %0h", i, rsp_data, f_exp[i]); end
            n_cmp++; if (rsp_err !== 1'b0) begin n_bad++; $display("FAIL full_err%0d: got %0b want 0", i, rsp_err); end
            ack_rsp();
        end
        repeat (3) @(negedge clk);
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL full_extra: rsp_valid=%0b want 0", rsp_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL full_idle: busy=%0b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        push_cmd(3'd4, 8'd1, 8'd2, 1'b0);
        push_cmd(3'd5, 8'd9, 8'd1, 1'b0);
        @(negedge clk);
        n_cmp++; if (in_selector !== 3'b010) begin n_bad++; $display("FAIL mid_in_wait: got %b want 010", in_selector); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (in_selector !== 3'b001) begin n_bad++; $display("FAIL mid_in_sel: got %b want 001", in_selector); end
        n_cmp++; if (num1 !== 8'h00 || num2 !== 8'h00) begin n_bad++; $display("FAIL mid_nums: got %0h,%0h want 0,0", num1, num2); end
        n_cmp++; if (out_selector !== 7'b0) begin n_bad++; $display("FAIL mid_out_sel: got %b want 0", out_selector); end
        n_cmp++; if (rsp_data !== 8'h00) begin n_bad++; $display("FAIL mid_rsp_data: got %0h want 0", rsp_data); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_busy: got %0b want 0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL mid_no_rsp%0d: rsp_valid=%0b want 0", i, rsp_valid); end
        end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_idle: busy=%0b want 0", busy); end
        n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL mid_cmd_ready: got %0b want 1", cmd_ready); end
        rsp_ready = 1'b0;
    endtask

    initial begin
        cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_chain = 1'b0;
        rsp_ready = 1'b0;
        test_reset();
        test_add();
        test_chain();
        test_illegal();
        test_overflow();
        test_fifo_full();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_cmd_driver.md
Name: alu_cmd_driver

Overview:
- Command-side driver for the 8-bit accumulator ALU. It queues operation requests from a host over a valid/ready handshake.
- For each request it sequences the ALU's input-mux select, operands and one-hot output select, then waits the ALU latency and captures the result and overflow.
- It returns each result to the host over a second valid/ready handshake.
- On an error it issues an accumulator reset, mirroring the ALU's off/ready/run/run_error control flow from the driving end.

Parameters:
WIDTH, 8, operand/result width
DEPTH, 4, command FIFO entries (power of 2)
ALU_LAT, 1, cycles from ALU inputs registered to outputVal valid

Ports:
clk  in  1  clock
rst_n  in  1  reset (one clock; reset is asynchronous and active-low)
cmd_valid  in  1  host command valid
cmd_ready  out  1  FIFO can accept
cmd_op  in  3  0 and, 1 or, 2 not, 3 xor, 4 add, 5 sub, 6 mult, 7 illegal
cmd_a  in  WIDTH  operand 1 (ignored when cmd_chain=1)
cmd_b  in  WIDTH  operand 2
cmd_chain  in  1  1 = use accumulator (persist) as operand 1
in_selector  out  3  to ALU: {persist, load, reset}, one-hot
num1  out  WIDTH  to ALU
num2  out  WIDTH  to ALU
out_selector  out  7  to ALU: {and, or, not, xor, add, sub, mult}, one-hot, bit6 = and
alu_result  in  WIDTH  ALU outputVal
alu_overflow  in  1  ALU multiply overflow
rsp_valid  out  1  result valid
rsp_ready  in  1  host accepts result
rsp_data  out  WIDTH  captured result
rsp_err  out  1  overflow or illegal op
busy  out  1  FSM not IDLE or FIFO non-empty

Behaviour:
- Reset values: in_selector=3'b001, num1=num2=0, out_selector=0, rsp_valid=0, rsp_data=0, rsp_err=0, FIFO empty, state IDLE.
  - cmd_ready=1 as soon as rst_n deasserts.
  - Reset mid-operation discards the in-flight command, all queued commands and any pending response.
- FIFO:
  - cmd_ready = !full.
  - Push on cmd_valid&&cmd_ready; pop in ISSUE.
  - Push and pop in the same cycle are both honoured, and count is unchanged.
  - Push is blocked when full, including when a pop occurs in the same cycle (cmd_ready is not combinationally dependent on pop).
  - Pointers wrap modulo DEPTH.
- All ALU-side outputs are registered. Outside ISSUE and ERROR: in_selector=3'b100 (persist, holds accumulator); out_selector holds the last issued value.
- FSM states: IDLE, ISSUE, WAIT, RESP, ERROR.
  - IDLE: FIFO non-empty -> ISSUE next cycle.
  - ISSUE (1 cycle): pop head.
    - Legal op: num1=cmd_a, num2=cmd_b, out_selector=one-hot(op), in_selector=3'b010 (load), or 3'b100 if chain. Load latency counter with ALU_LAT. -> WAIT.
    - Illegal op (7): no ALU drive change; rsp_data=0, rsp_err=1. -> RESP.
  - WAIT: decrement counter. At 0, capture rsp_data=alu_result and rsp_err=alu_overflow. -> RESP.
  - RESP: rsp_valid=1, rsp_data/rsp_err stable until rsp_ready.
    - On handshake, rsp_err=0 -> IDLE.
    - On handshake, rsp_err=1 -> ERROR.
  - ERROR (1 cycle): in_selector=3'b001, num1=num2=0 (accumulator cleared). -> IDLE.
- Minimum command-to-response latency: 2 + ALU_LAT cycles after push.
- Back-to-back: the next ISSUE occurs no earlier than the cycle after the RESP handshake; one command is in flight at a time.
- The overflow flag is captured for every legal op, not only mult.
- busy is combinational from state and FIFO count.

Test Plan:
- Reset then add a=8'd20, b=8'd22 -> ALU sees in_selector=010, out_selector=0000100. rsp_data=42, rsp_err=0, valid 3 cycles after push (ALU_LAT=1).
- Chain: load add 5+3, then chain mult b=4 -> second cmd in_selector=100. rsp_data=32.
- Mult a=8'd32, b=8'd16 with model overflow=1 -> rsp_err=1. Next cycle after handshake in_selector=001 for 1 cycle, then state IDLE.
- Push 5 cmds with rsp_ready=0 -> cmd_ready falls after 4 stored plus 1 issued. No loss, and responses come in order after rsp_ready=1.
- Illegal op 7 -> rsp_data=0, rsp_err=1, out_selector unchanged, ERROR reset pulse issued.
- Assert rst_n=0 during WAIT -> all outputs to reset values immediately, no rsp_valid after release, busy=0.
